// File: rtl/vram_arbiter_pkg.sv
// Shared constants and state encoding for the VRAM arbiter slice.
package vram_arbiter_pkg;

  localparam int VRAM_DEPTH = 4096;
  localparam int ADDR_W_DEF = $clog2(VRAM_DEPTH);
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VGA_ADDR = 3'd1,
    ST_VGA_DATA = 3'd2,
    ST_CPU_ADDR = 3'd3,
    ST_CPU_DATA = 3'd4
  } arb_state_e;

endpackage

// File: rtl/vram_arbiter_vga_change_detect.sv
// Tracks the last fetched VGA cell, raises a pending fetch on address change,
// and flags (sticky) any fetch that waits DEADLINE ungranted cycles.
module vga_change_detect
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEADLINE = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] vga_addr_i,
  input  logic              grant_i,
  output logic [ADDR_W-1:0] last_vga_o,
  output logic              pending_o,
  output logic              overrun_o
);

  localparam int CNT_W = $clog2(DEADLINE + 1);

  logic [ADDR_W-1:0] last_q, last_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovr_q, ovr_d;

  always_comb begin
    last_d = last_q;
    pend_d = pend_q | (vga_addr_i != last_q);
    cnt_d  = cnt_q;
    ovr_d  = ovr_q;
    if (grant_i) begin
      // The grant latches the live address, so a change in this cycle is absorbed.
      last_d = vga_addr_i;
      pend_d = 1'b0;
      cnt_d  = '0;
    end else if (pend_q) begin
      if (cnt_q != CNT_W'(DEADLINE)) cnt_d = cnt_q + 1'b1;
      if (cnt_q >= CNT_W'(DEADLINE - 1)) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= '0;
      pend_q <= 1'b1;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
    end
  end

  assign last_vga_o = last_q;
  assign pending_o  = pend_q;
  assign overrun_o  = ovr_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA cell fetches have strict priority, CPU
// req/ack accesses fill the gaps. Each access is an address cycle plus a data cycle.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEADLINE = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_e        state_q, state_d;
  logic              vga_grant, cpu_grant;
  logic [ADDR_W-1:0] last_vga;
  logic              vga_pending;
  logic [ADDR_W-1:0] cpu_addr_q;
  logic              cpu_we_q;
  logic [DATA_W-1:0] cpu_wdata_q;
  logic [DATA_W-1:0] vga_data_q, cpu_rdata_q;
  logic              cpu_ack_q;

  vga_change_detect #(
    .ADDR_W  (ADDR_W),
    .DEADLINE(DEADLINE)
  ) u_change_detect (
    .clk       (clk),
    .reset     (reset),
    .vga_addr_i(vga_addr),
    .grant_i   (vga_grant),
    .last_vga_o(last_vga),
    .pending_o (vga_pending),
    .overrun_o (vga_overrun)
  );

  always_comb begin
    state_d   = state_q;
    vga_grant = 1'b0;
    cpu_grant = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (vga_pending) begin
          vga_grant = 1'b1;
          state_d   = ST_VGA_ADDR;
        end else if (cpu_req && !cpu_ack_q) begin
          // A req still high during its own ack cycle must not re-grant.
          cpu_grant = 1'b1;
          state_d   = ST_CPU_ADDR;
        end
      end
      ST_VGA_ADDR: state_d = ST_VGA_DATA;
      ST_VGA_DATA: state_d = ST_IDLE;
      ST_CPU_ADDR: state_d = ST_CPU_DATA;
      ST_CPU_DATA: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // RAM drive is gated by reset so an aborted write never reaches the array.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (!reset) begin
      unique case (state_q)
        ST_VGA_ADDR, ST_VGA_DATA: ram_addr = last_vga;
        ST_CPU_ADDR: begin
          ram_addr  = cpu_addr_q;
          ram_we    = cpu_we_q;
          ram_wdata = cpu_wdata_q;
        end
        ST_CPU_DATA: ram_addr = cpu_addr_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cpu_addr_q  <= '0;
      cpu_we_q    <= 1'b0;
      cpu_wdata_q <= '0;
      vga_data_q  <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_ack_q <= (state_q == ST_CPU_DATA);
      if (cpu_grant) begin
        cpu_addr_q  <= cpu_addr;
        cpu_we_q    <= cpu_we;
        cpu_wdata_q <= cpu_wdata;
      end
      if (state_q == ST_VGA_DATA) vga_data_q <= ram_rdata;
      if (state_q == ST_CPU_DATA && !cpu_we_q) cpu_rdata_q <= ram_rdata;
    end
  end

  assign vga_data  = vga_data_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;

endmodule
